mc_ctrl: RTL

- Multicycle successor to the single-cycle MIPS control decoder.
- FSM sequences each instruction through IF/ID/EX/MEM/WB and drives the same datapath control encodings, now as per-state enables.
- Adds a req/rdy memory handshake for variable-latency memory, illegal-opcode and bus-timeout trapping, and a retired-instruction counter.
- Sits between the instruction register (op/funct fields) and the multicycle datapath.

---
 rtl/mc_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences IF/ID/EX/MEM/WB with a req/rdy memory
// handshake, illegal-opcode and bus-timeout traps, and a retired-instruction counter.
module mc_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned MEM_TO  = 0
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_rdy,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_sel,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_srcb,
    output logic               areg_sel,
    output logic [1:0]         npc_op,
    output logic [1:0]         gpr_sel,
    output logic [1:0]         wd_sel,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instret
);

    localparam int unsigned TO_W   = (MEM_TO < 2) ? 1 : $clog2(MEM_TO + 1);
    localparam int unsigned TO_LIM = (MEM_TO == 0) ? 0 : MEM_TO - 1;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_e;

    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                           ALU_OR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_NOR = 4'd7,
                           ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10;
    localparam logic [1:0] NPC_PLUS4 = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_JR = 2'd3;
    localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_R31 = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;

    state_e             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               retire_c, wait_c, to_hit_c;

    logic       dec_legal, dec_j, dec_jr, dec_jal, dec_jalr, dec_beq, dec_bne;
    logic       dec_lw, dec_sw, dec_rt, dec_shift, dec_ext, dec_srcb;
    logic [3:0] dec_alu;

    // Instruction decode from IR fields
    always_comb begin
        dec_legal = 1'b0; dec_j = 1'b0; dec_jr = 1'b0; dec_jal = 1'b0; dec_jalr = 1'b0;
        dec_beq = 1'b0; dec_bne = 1'b0; dec_lw = 1'b0; dec_sw = 1'b0; dec_rt = 1'b0;
        dec_shift = 1'b0; dec_ext = 1'b0; dec_srcb = 1'b0; dec_alu = ALU_NOP;
        case (op)
            6'h00: begin
                dec_legal = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h27:        dec_alu = ALU_NOR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h2B:        dec_alu = ALU_SLTU;
                    6'h00:        begin dec_alu = ALU_SLL; dec_shift = 1'b1; end
                    6'h02:        begin dec_alu = ALU_SRL; dec_shift = 1'b1; end
                    6'h03:        begin dec_alu = ALU_SRA; dec_shift = 1'b1; end
                    6'h08:        dec_jr = 1'b1;
                    6'h09:        dec_jalr = 1'b1;
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08: begin dec_legal = 1'b1; dec_rt = 1'b1; dec_alu = ALU_ADD; dec_ext = 1'b1; dec_srcb = 1'b1; end
            6'h0D: begin dec_legal = 1'b1; dec_rt = 1'b1; dec_alu = ALU_OR; dec_srcb = 1'b1; end
            6'h23: begin dec_legal = 1'b1; dec_rt = 1'b1; dec_lw = 1'b1; dec_alu = ALU_ADD; dec_ext = 1'b1; dec_srcb = 1'b1; end
            6'h2B: begin dec_legal = 1'b1; dec_sw = 1'b1; dec_alu = ALU_ADD; dec_ext = 1'b1; dec_srcb = 1'b1; end
            6'h04: begin dec_legal = 1'b1; dec_beq = 1'b1; dec_alu = ALU_SUB; end
            6'h05: begin dec_legal = 1'b1; dec_bne = 1'b1; dec_alu = ALU_SUB; end
            6'h02: begin dec_legal = 1'b1; dec_j = 1'b1; end
            6'h03: begin dec_legal = 1'b1; dec_jal = 1'b1; end
            default: ;
        endcase
    end

    // Bus timeout: rdy arriving on the limit cycle takes priority over the trap
    assign wait_c   = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_rdy;
    assign to_hit_c = (MEM_TO != 0) && wait_c && (to_cnt_q == TO_W'(TO_LIM));

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            S_IF: begin
                if (mem_rdy)       state_d = S_ID;
                else if (to_hit_c) state_d = S_TRAP;
            end
            S_ID: begin
                if (!dec_legal)                  state_d = S_TRAP;
                else if (dec_j || dec_jr)        begin state_d = S_IF; retire_c = 1'b1; end
                else if (dec_jal || dec_jalr)    state_d = S_WB;
                else                             state_d = S_EX;
            end
            S_EX: begin
                if (dec_beq || dec_bne)          begin state_d = S_IF; retire_c = 1'b1; end
                else if (dec_lw || dec_sw)       state_d = S_MEM;
                else                             state_d = S_WB;
            end
            S_MEM: begin
                if (mem_rdy) begin
                    if (dec_lw) state_d = S_WB;
                    else        begin state_d = S_IF; retire_c = 1'b1; end
                end else if (to_hit_c) begin
                    state_d = S_TRAP;
                end
            end
            S_WB:    begin state_d = S_IF; retire_c = 1'b1; end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        illegal_d = illegal_q | ((state_q == S_ID) && !dec_legal);
        bus_err_d = bus_err_q | to_hit_c;
        instret_d = instret_q + CNT_W'(retire_c);
        to_cnt_d  = '0;
        if ((MEM_TO != 0) && wait_c && (state_d == state_q)) to_cnt_d = to_cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Per-state datapath enables; everything is held at 0 while in reset
    always_comb begin
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
        reg_write = 1'b0; ext_op = 1'b0; alu_op = '0; alu_srcb = 1'b0; areg_sel = 1'b0;
        npc_op = NPC_PLUS4; gpr_sel = GPR_RD; wd_sel = WD_ALU;
        if (rstn) begin
            case (state_q)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin ir_write = 1'b1; pc_write = 1'b1; end
                end
                S_ID: begin
                    if (dec_j)       begin pc_write = 1'b1; npc_op = NPC_JUMP; end
                    else if (dec_jr) begin pc_write = 1'b1; npc_op = NPC_JR; end
                end
                S_EX: begin
                    alu_op   = ALUOP_W'(dec_alu);
                    alu_srcb = dec_srcb;
                    areg_sel = dec_shift;
                    ext_op   = dec_ext;
                    if (dec_beq || dec_bne) begin
                        npc_op   = NPC_BRANCH;
                        pc_write = (dec_beq & zero) | (dec_bne & ~zero);
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    mem_we  = dec_sw;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (dec_rt)                    gpr_sel = GPR_RT;
                    else if (dec_jal || dec_jalr)  gpr_sel = GPR_R31;
                    if (dec_lw)                    wd_sel = WD_MEM;
                    else if (dec_jal || dec_jalr)  wd_sel = WD_PC;
                    if (dec_jal)       begin pc_write = 1'b1; npc_op = NPC_JUMP; end
                    else if (dec_jalr) begin pc_write = 1'b1; npc_op = NPC_JR; end
                end
                default: ;
            endcase
        end
    end

    assign state_o = rstn ? 3'(state_q) : 3'd0;
    assign illegal = rstn & illegal_q;
    assign bus_err = rstn & bus_err_q;
    assign instret = rstn ? instret_q : '0;

endmodule
